// File: rtl/bresen_circle_gen.sv
// bresen_circle_gen: midpoint-circle rasteriser for the 2D primitive path.
// Walks one octant (x from radius down, y from 0 up) and mirrors each step
// into up to eight outline points or four horizontal fill spans. It clips
// to the visible screen, suppresses mirrored duplicates and streams the
// results over a valid/ready interface.
//
// Ports:
//   clk, n_rst       clock; synchronous active-high reset
//   start, abort     begin a draw (IDLE only) / cancel a running draw
//   fill, cx, cy,    draw mode, centre and radius, latched at start
//   radius
//   pix_valid/ready  output beat handshake
//   pix_x, pix_x1    point x, or span start/end x (inclusive)
//   pix_y            row
//   address          {pix_x, pix_y} for the frame-buffer arbiter
//   busy             high whenever not IDLE
//   done             one-cycle pulse when a draw completes
module bresen_circle_gen #(
   parameter int XW   = 10,
   parameter int YW   = 9,
   parameter int RW   = 9,
   parameter int XMAX = 639,
   parameter int YMAX = 479
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic               abort,
   input  logic               fill,
   input  logic [XW-1:0]      cx,
   input  logic [YW-1:0]      cy,
   input  logic [RW-1:0]      radius,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [XW-1:0]      pix_x,
   output logic [XW-1:0]      pix_x1,
   output logic [YW-1:0]      pix_y,
   output logic [XW+YW-1:0]   address,
   output logic               busy,
   output logic               done
);

   localparam int DW = RW + 2;   // decision variable
   localparam int CW = XW + 2;   // signed x arithmetic
   localparam int VW = YW + 2;   // signed y arithmetic

   localparam logic signed [CW-1:0] XMAX_S = CW'(XMAX);
   localparam logic signed [VW-1:0] YMAX_S = VW'(YMAX);
   localparam logic signed [DW-1:0] D_ONE   = DW'(1);
   localparam logic signed [DW-1:0] D_THREE = DW'(3);
   localparam logic signed [DW-1:0] D_FIVE  = DW'(5);
   localparam logic signed [RW:0]   R_ONE   = (RW+1)'(1);

   typedef enum logic [2:0] {IDLE, STEP, EMIT, UPDATE, FIN} state_t;

   state_t                 state;
   logic [XW-1:0]          cx_r;
   logic [YW-1:0]          cy_r;
   logic                   fill_r;
   // x is signed so that r=0 can step to x=-1 and terminate.
   logic signed [RW:0]     x, y;
   logic signed [DW-1:0]   d;
   logic [2:0]             k;

   logic signed [CW-1:0]   cxs, xh, yh, x0, x1;
   logic signed [VW-1:0]   cys, xv, yv, row;
   logic signed [DW-1:0]   xd, yd;
   logic                   skip, live, last_k;

   function automatic logic [XW-1:0] clamp_x(input logic signed [CW-1:0] v);
      if (v[CW-1])
         return '0;
      else if (v > XMAX_S)
         return XW'(XMAX);
      else
         return v[XW-1:0];
   endfunction

   assign cxs = $signed({2'b00, cx_r});
   assign cys = $signed({2'b00, cy_r});
   assign xh  = {{(CW-RW-1){x[RW]}}, x};
   assign yh  = {{(CW-RW-1){y[RW]}}, y};
   assign xv  = {{(VW-RW-1){x[RW]}}, x};
   assign yv  = {{(VW-RW-1){y[RW]}}, y};
   assign xd  = {{(DW-RW-1){x[RW]}}, x};
   assign yd  = {{(DW-RW-1){y[RW]}}, y};

   // Candidate k for the current octant step, plus its suppress/clip verdict.
   always_comb begin
      x0   = cxs;
      x1   = cxs;
      row  = cys;
      skip = 1'b0;
      if (fill_r) begin
         case (k)
            3'd0: begin x0 = cxs - xh; x1 = cxs + xh; row = cys + yv; end
            3'd1: begin x0 = cxs - xh; x1 = cxs + xh; row = cys - yv; end
            3'd2: begin x0 = cxs - yh; x1 = cxs + yh; row = cys + xv; end
            3'd3: begin x0 = cxs - yh; x1 = cxs + yh; row = cys - xv; end
            default: skip = 1'b1;
         endcase
         // y==0 makes the two x-spans the same row; x==y makes y-spans repeat x-spans.
         if ((k == 3'd1 && y == '0) || (k >= 3'd2 && x == y))
            skip = 1'b1;
      end else begin
         case (k)
            3'd0: begin x0 = cxs + xh; row = cys + yv; end
            3'd1: begin x0 = cxs + yh; row = cys + xv; end
            3'd2: begin x0 = cxs - yh; row = cys + xv; end
            3'd3: begin x0 = cxs - xh; row = cys + yv; end
            3'd4: begin x0 = cxs - xh; row = cys - yv; end
            3'd5: begin x0 = cxs - yh; row = cys - xv; end
            3'd6: begin x0 = cxs + yh; row = cys - xv; end
            default: begin x0 = cxs + xh; row = cys - yv; end
         endcase
         x1 = x0;
         if (x == '0)
            skip = (k != 3'd0);
         else if (y == '0)
            skip = (k == 3'd2 || k == 3'd4 || k == 3'd6 || k == 3'd7);
         else if (x == y)
            skip = (k == 3'd1 || k == 3'd2 || k == 3'd5 || k == 3'd6);
      end
      live   = !skip && !row[VW-1] && (row <= YMAX_S) && !x1[CW-1] && (x0 <= XMAX_S);
      last_k = fill_r ? (k == 3'd3) : (k == 3'd7);
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         state     <= IDLE;
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_x1    <= '0;
         pix_y     <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort && state != IDLE) begin
            state     <= IDLE;
            pix_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  cx_r   <= cx;
                  cy_r   <= cy;
                  fill_r <= fill;
                  x      <= $signed({1'b0, radius});
                  y      <= '0;
                  d      <= D_ONE - $signed({2'b00, radius});
                  state  <= STEP;
               end
               STEP: begin
                  if (x >= y) begin
                     k     <= 3'd0;
                     state <= EMIT;
                  end else begin
                     done  <= 1'b1;
                     state <= FIN;
                  end
               end
               EMIT: begin
                  // A presented beat holds until accepted; an idle cycle
                  // either loads a live candidate or skips a dead one.
                  if (pix_valid) begin
                     if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (last_k) state <= UPDATE;
                        else        k     <= k + 3'd1;
                     end
                  end else if (live) begin
                     pix_valid <= 1'b1;
                     pix_x     <= clamp_x(x0);
                     pix_x1    <= clamp_x(x1);
                     pix_y     <= row[YW-1:0];
                  end else begin
                     if (last_k) state <= UPDATE;
                     else        k     <= k + 3'd1;
                  end
               end
               UPDATE: begin
                  if (d[DW-1]) begin
                     d <= d + (yd <<< 1) + D_THREE;
                  end else begin
                     d <= d + ((yd - xd) <<< 1) + D_FIVE;
                     x <= x - R_ONE;
                  end
                  y     <= y + R_ONE;
                  state <= STEP;
               end
               FIN:     state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy    = (state != IDLE);
   assign address = {pix_x, pix_y};

endmodule
